// File: rtl/cdu_drive_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// cdu_drive_scheduler_pkg
// Shared definitions for the CDU drive scheduler: register offsets on the
// monitor bus, scheduler state encodings, pending-count limits and small
// helpers used by the scheduler and its round-robin arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package cdu_drive_scheduler_pkg;

    localparam int N_AXES = 5;

    typedef logic [15:0] word_t;
    typedef logic [N_AXES-1:0] axis_mask_t;

    // Register offsets (low three address bits; upper address bits must be 0)
    localparam logic [2:0] CDU_SCHED_REG_DX    = 3'd0;
    localparam logic [2:0] CDU_SCHED_REG_DY    = 3'd1;
    localparam logic [2:0] CDU_SCHED_REG_DZ    = 3'd2;
    localparam logic [2:0] CDU_SCHED_REG_DT    = 3'd3;
    localparam logic [2:0] CDU_SCHED_REG_DS    = 3'd4;
    localparam logic [2:0] CDU_SCHED_REG_CTRL  = 3'd5;
    localparam logic [2:0] CDU_SCHED_REG_GAP   = 3'd6;
    localparam logic [2:0] CDU_SCHED_REG_DROPS = 3'd7;

    // Scheduler state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic signed [17:0] PEND_MAX = 18'sd32767;
    localparam logic signed [17:0] PEND_MIN = -18'sd32767;

    // Clamp an 18-bit intermediate pending value to [-32767, +32767].
    function automatic word_t sat_pending(input logic signed [17:0] sum);
        if (sum > PEND_MAX)
            return 16'h7FFF;
        else if (sum < PEND_MIN)
            return 16'h8001;
        else
            return sum[15:0];
    endfunction

    // Index of the set bit of a one-hot axis mask (0 when the mask is empty).
    function automatic logic [2:0] onehot_to_idx(input axis_mask_t oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < N_AXES; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/cdu_drive_scheduler_if.sv
// -----------------------------------------------------------------------------
// cdu_drive_scheduler_if
// Monitor register bus as seen by the CDU drive scheduler.
//   read_en    : read strobe                    (master -> slave)
//   write_en   : write strobe                   (master -> slave)
//   addr[15:0] : register address               (master -> slave)
//   data_in    : write data                     (master -> slave)
//   write_done : one-cycle write acknowledge    (slave -> master)
//   data_out   : read data, 0 when not reading  (slave -> master)
// -----------------------------------------------------------------------------
interface cdu_drive_scheduler_if;
    logic        read_en;
    logic        write_en;
    logic        write_done;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;

    modport master (
        output read_en, write_en, addr, data_in,
        input  write_done, data_out
    );

    modport slave (
        input  read_en, write_en, addr, data_in,
        output write_done, data_out
    );
endinterface

// File: rtl/cdu_drive_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cdu_rr_arbiter
// Combinational 5-way round-robin picker. Searches from the axis after the
// last grant, in X..S order with wrap, and returns the first eligible axis.
//   eligible[4:0]   : axes that may be granted
//   last_grant[4:0] : one-hot last granted axis (register held by the parent)
//   grant[4:0]      : one-hot pick, all zero when nothing is eligible
// -----------------------------------------------------------------------------
module cdu_rr_arbiter
    import cdu_drive_scheduler_pkg::*;
(
    input  axis_mask_t eligible,
    input  axis_mask_t last_grant,
    output axis_mask_t grant
);

    logic [2:0] last_idx;
    logic [2:0] cand;
    logic       found;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        last_idx = onehot_to_idx(last_grant);
        cand     = 3'd0;
        // k = N_AXES lands back on the last-granted axis, so it is considered last
        for (int k = 1; k <= N_AXES; k++) begin
            cand = 3'((int'(last_idx) + k) % N_AXES);
            if (!found && eligible[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdu_drive_scheduler.sv
// -----------------------------------------------------------------------------
// cdu_drive_scheduler
// Issues CDU counter increment/decrement requests to the AGC for the five CDU
// counter cells (X, Y, Z, T, S). Software deposits signed pulse counts per
// axis; a round-robin scheduler shares the single request path, one request
// outstanding at a time, with a programmable idle gap between requests.
//
// Ports:
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   bus           : monitor register bus (slave modport)
//   cdu_ack[4:0]  : per-axis counter-serviced level from the AGC (bit0 = X)
//   pcdu[4:0]     : per-axis plus-count request level
//   mcdu[4:0]     : per-axis minus-count request level
//
// Parameter TIMEOUT_CYCLES: acknowledge wait limit in REQ.
// Optional feature macro CDU_SCHED_TIMEOUT_EN: when defined, a request with no
// acknowledge after TIMEOUT_CYCLES cycles is dropped and counted in DROPS.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no request; grant next eligible axis round-robin
// ST_REQ   | pcdu/mcdu driven for granted axis, waiting for ack rising edge
// ST_GAP   | inter-request spacing, counts GAP down to 0
// -----------------------------------------------------------------------------
module cdu_drive_scheduler
    import cdu_drive_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cdu_drive_scheduler_if.slave   bus,
    input  axis_mask_t             cdu_ack,
    output axis_mask_t             pcdu,
    output axis_mask_t             mcdu
);

    word_t      pending  [N_AXES];
    word_t      pend_next[N_AXES];
    axis_mask_t enable;
    word_t      gap_reg;
    word_t      drops;

    logic [1:0] state;
    axis_mask_t grant_oh;
    axis_mask_t last_grant;
    axis_mask_t arb_grant;
    axis_mask_t eligible;
    axis_mask_t ack_q;
    axis_mask_t ack_rise;
    logic       dir_minus;
    word_t      gap_cnt;

    logic       in_range;
    logic [2:0] reg_sel;
    logic       wr;
    logic       clear_all;
    logic       ack_hit;
    logic       complete;
    logic       grant_neg;
    logic       timeout_fire;
    word_t      rd_mux;

    assign in_range  = (bus.addr[15:3] == 13'd0);
    assign reg_sel   = bus.addr[2:0];
    assign wr        = bus.write_en && in_range;
    assign clear_all = wr && (reg_sel == CDU_SCHED_REG_CTRL) && bus.data_in[15];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_AXES; i++)
            eligible[i] = enable[i] && (pending[i] != 16'd0);
    end

    cdu_rr_arbiter u_arb (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    assign grant_neg = pending[onehot_to_idx(arb_grant)][15];

    // Ack edges from non-granted axes are masked out by grant_oh.
    assign ack_rise = cdu_ack & ~ack_q;
    assign ack_hit  = |(ack_rise & grant_oh);
    assign complete = (state == ST_REQ) && ack_hit && !clear_all;

    // Bus addend and completion both land in the same update.
    always_comb begin
        for (int i = 0; i < N_AXES; i++) begin
            logic signed [17:0] sum;
            logic signed [17:0] addend;
            logic signed [17:0] issued;
            addend = (wr && (reg_sel == 3'(i))) ? 18'($signed(bus.data_in)) : 18'sd0;
            if (complete && grant_oh[i])
                issued = dir_minus ? -18'sd1 : 18'sd1;
            else
                issued = 18'sd0;
            sum          = 18'($signed(pending[i])) + addend - issued;
            pend_next[i] = sat_pending(sum);
        end
    end

`ifdef CDU_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;

    assign timeout_fire = (state == ST_REQ) && !ack_hit && !clear_all && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drops <= '0;
        else if (wr && (reg_sel == CDU_SCHED_REG_DROPS))
            drops <= '0;
        else if (timeout_fire && (drops != 16'hFFFF))
            drops <= drops + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state != ST_REQ)
            to_cnt <= '0;
        else if (!timeout_fire)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_fire   = 1'b0;
    assign drops          = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            CDU_SCHED_REG_DX:    rd_mux = pending[0];
            CDU_SCHED_REG_DY:    rd_mux = pending[1];
            CDU_SCHED_REG_DZ:    rd_mux = pending[2];
            CDU_SCHED_REG_DT:    rd_mux = pending[3];
            CDU_SCHED_REG_DS:    rd_mux = pending[4];
            CDU_SCHED_REG_CTRL:  rd_mux = {11'd0, enable};
            CDU_SCHED_REG_GAP:   rd_mux = gap_reg;
            CDU_SCHED_REG_DROPS: rd_mux = drops;
            default:             rd_mux = '0;
        endcase
    end

    // Register file and bus responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_AXES; i++)
                pending[i] <= '0;
            enable         <= '0;
            gap_reg        <= '0;
            bus.write_done <= 1'b0;
            bus.data_out   <= '0;
        end else begin
            bus.write_done <= bus.write_en;
            bus.data_out   <= (bus.read_en && in_range) ? rd_mux : 16'd0;
            for (int i = 0; i < N_AXES; i++)
                pending[i] <= clear_all ? 16'd0 : pend_next[i];
            if (wr && (reg_sel == CDU_SCHED_REG_CTRL))
                enable <= bus.data_in[4:0];
            if (wr && (reg_sel == CDU_SCHED_REG_GAP))
                gap_reg <= bus.data_in;
        end
    end

    // Scheduler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_oh   <= '0;
            last_grant <= 5'b10000;
            dir_minus  <= 1'b0;
            gap_cnt    <= '0;
            pcdu       <= '0;
            mcdu       <= '0;
            ack_q      <= '0;
        end else begin
            ack_q <= cdu_ack;
            if (clear_all) begin
                state    <= ST_IDLE;
                grant_oh <= '0;
                pcdu     <= '0;
                mcdu     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (|eligible) begin
                            grant_oh   <= arb_grant;
                            last_grant <= arb_grant;
                            dir_minus  <= grant_neg;
                            pcdu       <= grant_neg ? 5'd0 : arb_grant;
                            mcdu       <= grant_neg ? arb_grant : 5'd0;
                            state      <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (ack_hit || timeout_fire) begin
                            pcdu    <= '0;
                            mcdu    <= '0;
                            gap_cnt <= gap_reg;
                            state   <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == 16'd0)
                            state <= ST_IDLE;
                        else
                            gap_cnt <= gap_cnt - 16'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        pcdu  <= '0;
                        mcdu  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdu_drive_scheduler.sv
module tb_cdu_drive_scheduler;
    import cdu_drive_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] cdu_ack;
    logic [4:0] pcdu;
    logic [4:0] mcdu;

    cdu_drive_scheduler_if bus ();

    cdu_drive_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cdu_ack (cdu_ack),
        .pcdu    (pcdu),
        .mcdu    (mcdu)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus.addr     = {13'd0, a};
        bus.data_in  = d;
        bus.write_en = 1'b1;
        step();
        bus.write_en = 1'b0;
        check("write_done", {31'd0, bus.write_done}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        bus.addr    = {13'd0, a};
        bus.read_en = 1'b1;
        step();
        bus.read_en = 1'b0;
        check(tag, {16'd0, bus.data_out}, {16'd0, exp});
    endtask

    task automatic wait_req(input string tag, input int maxc);
        int n;
        n = 0;
        while (pcdu == 5'd0 && mcdu == 5'd0 && n < maxc) begin
            step();
            n++;
        end
        if (pcdu == 5'd0 && mcdu == 5'd0)
            check({tag, "_wait_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic quiet_check(input string tag, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (pcdu != 5'd0 || mcdu != 5'd0) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    logic [4:0] rr_p [4];
    logic [4:0] rr_m [4];
    int t_drop;
    int n_hi;

    initial begin
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
        bus.addr     = 16'd0;
        bus.data_in  = 16'd0;
        cdu_ack      = 5'd0;
        t_drop       = 0;

        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_pcdu", {27'd0, pcdu}, 32'd0);
        check("rst_mcdu", {27'd0, mcdu}, 32'd0);
        check("rst_write_done", {31'd0, bus.write_done}, 32'd0);
        check("rst_data_out", {16'd0, bus.data_out}, 32'd0);
        for (int a = 0; a < 8; a++)
            read_check("rst_reg", 3'(a), 16'h0000);

        // Acknowledge handling: X enabled, GAP=4, DX=3, ack 2 cycles after request
        bus_write(CDU_SCHED_REG_CTRL, 16'h0001);
        bus_write(CDU_SCHED_REG_GAP, 16'd4);
        read_check("gap_rd", CDU_SCHED_REG_GAP, 16'd4);
        bus_write(CDU_SCHED_REG_DX, 16'd3);
        check("grant_n1", {27'd0, pcdu}, 32'd0);
        step();
        check("grant_n2", {27'd0, pcdu}, 32'd1);
        for (int p = 0; p < 3; p++) begin
            if (p > 0) begin
                wait_req("ack_seq", 40);
                check("ack_spacing", 32'(cyc - t_drop), 32'd6);
            end
            check("ack_pcdu", {27'd0, pcdu}, 32'd1);
            check("ack_mcdu", {27'd0, mcdu}, 32'd0);
            step();
            step();
            check("ack_hold", {27'd0, pcdu}, 32'd1);
            cdu_ack = 5'b00001;
            step();
            check("ack_drop", {27'd0, pcdu}, 32'd0);
            t_drop  = cyc;
            cdu_ack = 5'b00000;
            read_check("ack_dx", CDU_SCHED_REG_DX, 16'(3 - (p + 1)));
        end
        quiet_check("ack_no_extra", 20);
        check("data_out_idle", {16'd0, bus.data_out}, 32'd0);

        // Reset in the middle of a request drops the lines at once
        bus_write(CDU_SCHED_REG_DX, 16'd1);
        wait_req("rst_req", 20);
        check("rst_req_up", {27'd0, pcdu}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {27'd0, pcdu}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        read_check("rst_dx", CDU_SCHED_REG_DX, 16'd0);

        // Round-robin: DX=2, DZ=-1, DS=1 -> X, Z(minus), S, X
        bus_write(CDU_SCHED_REG_DX, 16'd2);
        bus_write(CDU_SCHED_REG_DZ, 16'hFFFF);
        bus_write(CDU_SCHED_REG_DS, 16'd1);
        bus_write(CDU_SCHED_REG_GAP, 16'd0);
        quiet_check("rr_disabled_quiet", 4);
        bus_write(CDU_SCHED_REG_CTRL, 16'h001F);
        rr_p[0] = 5'b00001; rr_m[0] = 5'b00000;
        rr_p[1] = 5'b00000; rr_m[1] = 5'b00100;
        rr_p[2] = 5'b10000; rr_m[2] = 5'b00000;
        rr_p[3] = 5'b00001; rr_m[3] = 5'b00000;
        for (int k = 0; k < 4; k++) begin
            wait_req("rr", 40);
            check("rr_pcdu", {27'd0, pcdu}, {27'd0, rr_p[k]});
            check("rr_mcdu", {27'd0, mcdu}, {27'd0, rr_m[k]});
            cdu_ack = rr_p[k] | rr_m[k];
            step();
            check("rr_drop", {27'd0, pcdu | mcdu}, 32'd0);
            cdu_ack = 5'd0;
        end
        quiet_check("rr_no_extra", 20);
        read_check("rr_dx", CDU_SCHED_REG_DX, 16'd0);
        read_check("rr_dz", CDU_SCHED_REG_DZ, 16'd0);
        read_check("rr_ds", CDU_SCHED_REG_DS, 16'd0);

        // Concurrent write and completion on Y: 1 + 5 - 1 = 5
        bus_write(CDU_SCHED_REG_DY, 16'd1);
        wait_req("conc", 20);
        check("conc_pcdu", {27'd0, pcdu}, 32'd2);
        cdu_ack      = 5'b00010;
        bus.addr     = {13'd0, CDU_SCHED_REG_DY};
        bus.data_in  = 16'd5;
        bus.write_en = 1'b1;
        step();
        bus.write_en = 1'b0;
        cdu_ack      = 5'd0;
        check("conc_write_done", {31'd0, bus.write_done}, 32'd1);
        check("conc_drop", {27'd0, pcdu | mcdu}, 32'd0);
        read_check("conc_dy", CDU_SCHED_REG_DY, 16'd5);
        wait_req("conc_next", 20);
        check("conc_next_y", {27'd0, pcdu}, 32'd2);

        // Clear-all during REQ, with an ack in the same cycle
        bus_write(CDU_SCHED_REG_DX, 16'd7);
        check("clr_still_req", {27'd0, pcdu}, 32'd2);
        cdu_ack      = 5'b00010;
        bus.addr     = {13'd0, CDU_SCHED_REG_CTRL};
        bus.data_in  = 16'h801F;
        bus.write_en = 1'b1;
        step();
        bus.write_en = 1'b0;
        cdu_ack      = 5'd0;
        check("clr_pcdu", {27'd0, pcdu}, 32'd0);
        check("clr_mcdu", {27'd0, mcdu}, 32'd0);
        read_check("clr_dy", CDU_SCHED_REG_DY, 16'd0);
        cdu_ack = 5'b00010;
        step();
        cdu_ack = 5'd0;
        read_check("clr_dx", CDU_SCHED_REG_DX, 16'd0);
        read_check("clr_dy_late_ack", CDU_SCHED_REG_DY, 16'd0);
        read_check("clr_ctrl", CDU_SCHED_REG_CTRL, 16'h001F);
        quiet_check("clr_quiet", 10);

        // Saturation at both ends
        bus_write(CDU_SCHED_REG_CTRL, 16'h0000);
        bus_write(CDU_SCHED_REG_DX, 16'h7000);
        bus_write(CDU_SCHED_REG_DX, 16'h7000);
        read_check("sat_pos", CDU_SCHED_REG_DX, 16'h7FFF);
        bus_write(CDU_SCHED_REG_DX, 16'h8000);
        read_check("sat_wrap_back", CDU_SCHED_REG_DX, 16'hFFFF);
        bus_write(CDU_SCHED_REG_DX, 16'h8000);
        read_check("sat_neg", CDU_SCHED_REG_DX, 16'h8001);
        bus_write(CDU_SCHED_REG_CTRL, 16'h8000);
        read_check("sat_cleared", CDU_SCHED_REG_DX, 16'h0000);

`ifdef CDU_SCHED_TIMEOUT_EN
        // Timeout: request held 16 cycles, dropped, counted, then retried
        bus_write(CDU_SCHED_REG_CTRL, 16'h0001);
        bus_write(CDU_SCHED_REG_GAP, 16'd2);
        bus_write(CDU_SCHED_REG_DX, 16'd1);
        wait_req("to", 20);
        n_hi = 0;
        while (pcdu != 5'd0 && n_hi < 40) begin
            step();
            n_hi++;
        end
        check("to_len", 32'(n_hi), 32'd16);
        t_drop = cyc;
        read_check("to_drops", CDU_SCHED_REG_DROPS, 16'd1);
        read_check("to_dx", CDU_SCHED_REG_DX, 16'd1);
        wait_req("to_retry", 20);
        check("to_retry_gap", 32'(cyc - t_drop), 32'd4);
        check("to_retry_pcdu", {27'd0, pcdu}, 32'd1);
        cdu_ack = 5'b00001;
        step();
        cdu_ack = 5'd0;
        read_check("to_dx_done", CDU_SCHED_REG_DX, 16'd0);
        bus_write(CDU_SCHED_REG_DROPS, 16'h1234);
        read_check("to_drops_clr", CDU_SCHED_REG_DROPS, 16'd0);
`else
        bus_write(CDU_SCHED_REG_DROPS, 16'd5);
        read_check("drops_disabled", CDU_SCHED_REG_DROPS, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
